// File: rtl/imem_port_arbiter.sv
// Two-requester (fetch / loader) arbiter in front of a single-port sync-read imem bank.
// Optional error outputs f_err/l_err are enabled by defining IMEM_ARB_ERR_EN.
module imem_port_arbiter #(
  parameter int DEPTH      = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_req,
  input  logic [31:0]              f_addr,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [31:0]              f_rdata,
  input  logic                     l_req,
  input  logic                     l_we,
  input  logic [31:0]              l_addr,
  input  logic [31:0]              l_wdata,
  output logic                     l_gnt,
  output logic                     l_rvalid,
  output logic [31:0]              l_rdata,
  output logic                     m_en,
  output logic                     m_we,
  output logic [$clog2(DEPTH)-1:0] m_addr,
  output logic [31:0]              m_wdata,
  input  logic [31:0]              m_rdata
`ifdef IMEM_ARB_ERR_EN
  ,
  output logic                     f_err,
  output logic                     l_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, F_RESP, L_RESP, ERR_F, ERR_L} rsp_e;

  rsp_e        state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        l_wr_q, l_wr_d;
  logic        err_q, err_d;
  logic [31:0] f_rdata_q, l_rdata_q;
  logic        f_inr, l_inr;
  logic [31:0] sel_addr;

  assign f_inr = (f_addr[31:2] < 30'(DEPTH));
  assign l_inr = (l_addr[31:2] < 30'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      l_wr_q    <= 1'b0;
      err_q     <= 1'b0;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      l_wr_q    <= l_wr_d;
      err_q     <= err_d;
      f_rdata_q <= f_rdata;
      l_rdata_q <= l_rdata;
    end
  end

  // Issue side: arbitration, starvation guard and RAM command for this cycle.
  always_comb begin
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    starve_d = '0;
    state_d  = IDLE;
    l_wr_d   = 1'b0;
    err_d    = 1'b0;

    if (f_req && (!l_req || starve_q == 4'(STARVE_MAX)))
      f_gnt = 1'b1;
    else if (l_req)
      l_gnt = 1'b1;

    if (f_req && !f_gnt)
      starve_d = (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;

    sel_addr = f_gnt ? f_addr : l_addr;
    m_en     = (f_gnt && f_inr) || (l_gnt && l_inr);
    m_we     = l_gnt && l_we && l_inr;
    m_addr   = sel_addr[AW+1:2];
    m_wdata  = l_wdata;

    if (f_gnt) begin
      state_d = f_inr ? F_RESP : ERR_F;
      err_d   = !f_inr || (f_addr[1:0] != 2'b00);
    end else if (l_gnt) begin
      state_d = l_inr ? L_RESP : ERR_L;
      l_wr_d  = l_we;
      err_d   = !l_inr || (l_addr[1:0] != 2'b00);
    end
  end

  // Response side: owner of last cycle's access sees rvalid; the other side holds its data.
  always_comb begin
    f_rvalid = (state_q == F_RESP) || (state_q == ERR_F);
    l_rvalid = (state_q == L_RESP) || (state_q == ERR_L);
    f_rdata  = f_rdata_q;
    l_rdata  = l_rdata_q;
    if (state_q == F_RESP)      f_rdata = m_rdata;
    else if (state_q == ERR_F)  f_rdata = '0;
    if (state_q == L_RESP)      l_rdata = l_wr_q ? 32'h0 : m_rdata;
    else if (state_q == ERR_L)  l_rdata = '0;
  end

`ifdef IMEM_ARB_ERR_EN
  assign f_err = f_rvalid && err_q;
  assign l_err = l_rvalid && err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
